// File: rtl/int_control_nested.sv
// ============================================================================
// Module   : int_control_nested
// Brief    : N-channel edge-triggered interrupt controller with priority
//            preemption; in-service bitmap tracks nested handlers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module int_control_nested #(
    parameter  int N_CH = 4,
    localparam int ID_W = $clog2(N_CH)
) (
    input  logic            clk,
    input  logic            clr,
    input  logic [N_CH-1:0] int_signal,
    input  logic [N_CH-1:0] int_mask,
    input  logic            int_enable,
    input  logic            int_ack,
    input  logic            eret,
    output logic            int_request,
    output logic [ID_W-1:0] int_num,
    output logic [N_CH-1:0] int_waiting,
    output logic [N_CH-1:0] in_service,
    output logic [N_CH-1:0] int_overrun
);

    logic [N_CH-1:0] r_sig_q;
    logic [N_CH-1:0] r_pending;
    logic [N_CH-1:0] r_in_service;
    logic [N_CH-1:0] r_overrun;

    logic [N_CH-1:0] w_edge;
    logic [N_CH-1:0] w_elig;
    logic [N_CH-1:0] w_ack_vec;
    logic [N_CH-1:0] w_eret_vec;
    logic [ID_W-1:0] w_top_p;
    logic [ID_W-1:0] w_top_s;
    logic            w_any_p;
    logic            w_any_s;
    logic            w_request;
    logic            w_ack;

    assign w_edge = int_signal & ~r_sig_q;
    assign w_elig = r_pending & ~int_mask;

    // Ascending scan: the last set bit seen is the highest index.
    always_comb begin
        w_top_p = '0;
        w_any_p = 1'b0;
        w_top_s = '0;
        w_any_s = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_elig[i]) begin
                w_top_p = ID_W'(i);
                w_any_p = 1'b1;
            end
            if (r_in_service[i]) begin
                w_top_s = ID_W'(i);
                w_any_s = 1'b1;
            end
        end
    end

    assign w_request = int_enable & w_any_p & (~w_any_s | (w_top_p > w_top_s));
    assign w_ack     = int_ack & w_request;

    generate
        for (genvar g = 0; g < N_CH; g++) begin : g_ch
            assign w_ack_vec[g]  = w_ack & (w_top_p == ID_W'(g));
            assign w_eret_vec[g] = eret & w_any_s & (w_top_s == ID_W'(g));
        end
    endgenerate

    // An edge arriving with its own ack re-arms pending without flagging overrun.
    always_ff @(posedge clk) begin
        r_sig_q <= int_signal;
        if (clr) begin
            r_pending    <= '0;
            r_in_service <= '0;
            r_overrun    <= '0;
        end else begin
            r_pending    <= (r_pending & ~w_ack_vec) | w_edge;
            r_overrun    <= (r_overrun | (w_edge & r_pending)) & ~w_ack_vec;
            r_in_service <= (r_in_service & ~w_eret_vec) | w_ack_vec;
        end
    end

    assign int_request = w_request;
    assign int_num     = w_request ? w_top_p : '0;
    assign int_waiting = r_pending | r_in_service;
    assign in_service  = r_in_service;
    assign int_overrun = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_int_control_nested.sv
// Self-checking bench for int_control_nested: directed scenarios on 4 and 32
// channels plus randomized traffic against a stack-based reference model.
`default_nettype none

module tb_int_control_nested;

    logic        clk;
    logic        clr, en, ack, eret;
    logic [3:0]  sig4, mask4;
    logic        req4;
    logic [1:0]  num4;
    logic [3:0]  wait4, insvc4, ovr4;

    logic        clr32, en32, ack32, eret32;
    logic [31:0] sig32, mask32;
    logic        req32;
    logic [4:0]  num32;
    logic [31:0] wait32, insvc32, ovr32;

    int n_err;
    int n_checks;

    int_control_nested #(.N_CH(4)) dut4 (
        .clk(clk), .clr(clr), .int_signal(sig4), .int_mask(mask4),
        .int_enable(en), .int_ack(ack), .eret(eret),
        .int_request(req4), .int_num(num4), .int_waiting(wait4),
        .in_service(insvc4), .int_overrun(ovr4)
    );

    int_control_nested #(.N_CH(32)) dut32 (
        .clk(clk), .clr(clr32), .int_signal(sig32), .int_mask(mask32),
        .int_enable(en32), .int_ack(ack32), .eret(eret32),
        .int_request(req32), .int_num(num32), .int_waiting(wait32),
        .in_service(insvc32), .int_overrun(ovr32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model of the 4-channel instance: handlers kept as a stack of
    // channel numbers, pending/overrun as plain bit sets.
    bit [3:0] m_pend, m_ovr, m_sigq;
    int       m_stack[$];

    function automatic int m_top_p();
        for (int i = 3; i >= 0; i--)
            if (m_pend[i] && !mask4[i]) return i;
        return -1;
    endfunction

    function automatic int m_top_s();
        if (m_stack.size() == 0) return -1;
        return m_stack[m_stack.size()-1];
    endfunction

    function automatic bit m_req();
        int tp;
        tp = m_top_p();
        return en && (tp >= 0) && (tp > m_top_s());
    endfunction

    function automatic logic [1:0] m_num();
        if (m_req()) return 2'(m_top_p());
        return 2'd0;
    endfunction

    function automatic logic [3:0] m_insvc();
        logic [3:0] v;
        v = '0;
        foreach (m_stack[k]) v[m_stack[k]] = 1'b1;
        return v;
    endfunction

    task automatic m_update();
        bit       r;
        int       n;
        bit [3:0] e;
        r = m_req();
        n = m_top_p();
        e = sig4 & ~m_sigq;
        m_sigq = sig4;
        if (clr) begin
            m_pend = '0;
            m_ovr  = '0;
            m_stack.delete();
            return;
        end
        if (eret && m_stack.size() > 0) void'(m_stack.pop_back());
        for (int i = 0; i < 4; i++)
            if (e[i] && m_pend[i] && !(ack && r && n == i)) m_ovr[i] = 1'b1;
        if (ack && r) begin
            m_pend[n] = 1'b0;
            m_ovr[n]  = 1'b0;
            m_stack.push_back(n);
        end
        m_pend = m_pend | e;
    endtask

    task automatic step();
        @(posedge clk);
        m_update();
        @(negedge clk);
    endtask

    task automatic test_reset();
        clr = 1'b1; clr32 = 1'b1;
        step();
        clr = 1'b0; clr32 = 1'b0;
        #1;
        n_checks++; if (req4 !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", req4); end
        n_checks++; if (num4 !== 2'd0) begin n_err++; $display("FAIL reset_num: got %0d want 0", num4); end
        n_checks++; if (wait4 !== 4'b0) begin n_err++; $display("FAIL reset_wait: got %b want 0000", wait4); end
        n_checks++; if (insvc4 !== 4'b0) begin n_err++; $display("FAIL reset_insvc: got %b want 0000", insvc4); end
        n_checks++; if (ovr4 !== 4'b0) begin n_err++; $display("FAIL reset_ovr: got %b want 0000", ovr4); end
        n_checks++; if ({req32, wait32, insvc32, ovr32} !== 97'b0) begin n_err++; $display("FAIL reset32: got req=%b wait=%h insvc=%h", req32, wait32, insvc32); end
    endtask

    task automatic test_basic();
        sig4 = 4'b0010;
        #1;
        n_checks++; if (req4 !== 1'b0) begin n_err++; $display("FAIL basic_pre: got %b want 0", req4); end
        step();
        #1;
        n_checks++; if (req4 !== 1'b1 || num4 !== 2'd1) begin n_err++; $display("FAIL basic_req: got req=%b num=%0d want 1/1", req4, num4); end
        ack = 1'b1; step(); ack = 1'b0; #1;
        n_checks++; if (insvc4 !== 4'b0010 || req4 !== 1'b0) begin n_err++; $display("FAIL basic_ack: got insvc=%b req=%b want 0010/0", insvc4, req4); end
        eret = 1'b1; sig4 = 4'b0; step(); eret = 1'b0; #1;
        n_checks++; if (insvc4 !== 4'b0 || wait4 !== 4'b0) begin n_err++; $display("FAIL basic_eret: got insvc=%b wait=%b want 0000/0000", insvc4, wait4); end
    endtask

    task automatic test_nesting();
        sig4 = 4'b0101; step(); sig4 = 4'b0; #1;
        n_checks++; if (req4 !== 1'b1 || num4 !== 2'd2) begin n_err++; $display("FAIL nest_prio: got req=%b num=%0d want 1/2", req4, num4); end
        ack = 1'b1; step(); ack = 1'b0; #1;
        n_checks++; if (insvc4 !== 4'b0100 || req4 !== 1'b0) begin n_err++; $display("FAIL nest_ack2: got insvc=%b req=%b want 0100/0", insvc4, req4); end
        sig4 = 4'b1000; step(); sig4 = 4'b0; #1;
        n_checks++; if (req4 !== 1'b1 || num4 !== 2'd3) begin n_err++; $display("FAIL nest_preempt: got req=%b num=%0d want 1/3", req4, num4); end
        ack = 1'b1; step(); ack = 1'b0; #1;
        n_checks++; if (insvc4 !== 4'b1100) begin n_err++; $display("FAIL nest_stack: got %b want 1100", insvc4); end
        eret = 1'b1; step(); eret = 1'b0; #1;
        n_checks++; if (insvc4 !== 4'b0100 || req4 !== 1'b0) begin n_err++; $display("FAIL nest_eret1: got insvc=%b req=%b want 0100/0", insvc4, req4); end
        eret = 1'b1; step(); eret = 1'b0; #1;
        n_checks++; if (insvc4 !== 4'b0 || req4 !== 1'b1 || num4 !== 2'd0) begin n_err++; $display("FAIL nest_eret2: got insvc=%b req=%b num=%0d want 0000/1/0", insvc4, req4, num4); end
        ack = 1'b1; step(); ack = 1'b0;
        eret = 1'b1; step(); eret = 1'b0; #1;
        n_checks++; if (wait4 !== 4'b0) begin n_err++; $display("FAIL nest_clean: got %b want 0000", wait4); end
    endtask

    task automatic test_no_preempt();
        sig4 = 4'b0100; step(); sig4 = 4'b0;
        ack = 1'b1; step(); ack = 1'b0;
        sig4 = 4'b0010; step(); sig4 = 4'b0; #1;
        n_checks++; if (req4 !== 1'b0 || wait4 !== 4'b0110) begin n_err++; $display("FAIL nopre_lower: got req=%b wait=%b want 0/0110", req4, wait4); end
        eret = 1'b1; step(); eret = 1'b0; #1;
        n_checks++; if (req4 !== 1'b1 || num4 !== 2'd1) begin n_err++; $display("FAIL nopre_eret: got req=%b num=%0d want 1/1", req4, num4); end
        ack = 1'b1; step(); ack = 1'b0;
        eret = 1'b1; step(); eret = 1'b0;
    endtask

    task automatic test_mask_enable();
        mask4 = 4'b0100; sig4 = 4'b0100; step(); sig4 = 4'b0; #1;
        n_checks++; if (req4 !== 1'b0 || wait4 !== 4'b0100) begin n_err++; $display("FAIL mask_hold: got req=%b wait=%b want 0/0100", req4, wait4); end
        mask4 = 4'b0; #1;
        n_checks++; if (req4 !== 1'b1 || num4 !== 2'd2) begin n_err++; $display("FAIL mask_unmask: got req=%b num=%0d want 1/2", req4, num4); end
        en = 1'b0; #1;
        n_checks++; if (req4 !== 1'b0 || num4 !== 2'd0) begin n_err++; $display("FAIL enable_off: got req=%b num=%0d want 0/0", req4, num4); end
        ack = 1'b1; step(); ack = 1'b0; #1;
        n_checks++; if (insvc4 !== 4'b0 || wait4 !== 4'b0100) begin n_err++; $display("FAIL ack_ignored: got insvc=%b wait=%b want 0000/0100", insvc4, wait4); end
        en = 1'b1;
        ack = 1'b1; step(); ack = 1'b0;
        eret = 1'b1; step(); eret = 1'b0;
    endtask

    task automatic test_overrun();
        sig4 = 4'b0010; step(); sig4 = 4'b0; step();
        sig4 = 4'b0010; step(); sig4 = 4'b0; #1;
        n_checks++; if (ovr4 !== 4'b0010 || wait4 !== 4'b0010 || num4 !== 2'd1) begin n_err++; $display("FAIL ovr_set: got ovr=%b wait=%b num=%0d want 0010/0010/1", ovr4, wait4, num4); end
        ack = 1'b1; step(); ack = 1'b0; #1;
        n_checks++; if (ovr4 !== 4'b0 || insvc4 !== 4'b0010) begin n_err++; $display("FAIL ovr_ack: got ovr=%b insvc=%b want 0000/0010", ovr4, insvc4); end
        eret = 1'b1; step(); eret = 1'b0;
        sig4 = 4'b0010; step(); sig4 = 4'b0; step();
        sig4 = 4'b0010; ack = 1'b1; step(); sig4 = 4'b0; ack = 1'b0; #1;
        n_checks++; if (insvc4 !== 4'b0010 || wait4 !== 4'b0010 || ovr4 !== 4'b0 || req4 !== 1'b0) begin n_err++; $display("FAIL coalesce: got insvc=%b wait=%b ovr=%b req=%b want 0010/0010/0000/0", insvc4, wait4, ovr4, req4); end
        eret = 1'b1; step(); eret = 1'b0; #1;
        n_checks++; if (req4 !== 1'b1 || num4 !== 2'd1) begin n_err++; $display("FAIL coalesce_rearm: got req=%b num=%0d want 1/1", req4, num4); end
        ack = 1'b1; step(); ack = 1'b0;
        eret = 1'b1; step(); eret = 1'b0;
    endtask

    task automatic test_reset_mid();
        sig4 = 4'b1000; step();
        ack = 1'b1; step(); ack = 1'b0; #1;
        n_checks++; if (insvc4 !== 4'b1000) begin n_err++; $display("FAIL mid_insvc: got %b want 1000", insvc4); end
        clr = 1'b1; ack = 1'b1; step(); clr = 1'b0; ack = 1'b0; #1;
        n_checks++; if ({req4, num4, wait4, insvc4, ovr4} !== 15'b0) begin n_err++; $display("FAIL mid_reset: got req=%b num=%0d wait=%b insvc=%b ovr=%b want all 0", req4, num4, wait4, insvc4, ovr4); end
        step(); #1;
        n_checks++; if (req4 !== 1'b0 || wait4 !== 4'b0) begin n_err++; $display("FAIL mid_held: got req=%b wait=%b want 0/0000", req4, wait4); end
        sig4 = 4'b0; step();
    endtask

    task automatic test_wide();
        sig32 = 32'h4000_0000; step(); sig32 = '0; #1;
        n_checks++; if (req32 !== 1'b1 || num32 !== 5'd30) begin n_err++; $display("FAIL wide_30: got req=%b num=%0d want 1/30", req32, num32); end
        ack32 = 1'b1; step(); ack32 = 1'b0;
        sig32 = 32'h8000_0000; step(); sig32 = '0; #1;
        n_checks++; if (req32 !== 1'b1 || num32 !== 5'd31) begin n_err++; $display("FAIL wide_preempt: got req=%b num=%0d want 1/31", req32, num32); end
        ack32 = 1'b1; step(); ack32 = 1'b0; #1;
        n_checks++; if (insvc32 !== 32'hC000_0000 || req32 !== 1'b0) begin n_err++; $display("FAIL wide_stack: got insvc=%h req=%b want c0000000/0", insvc32, req32); end
        eret32 = 1'b1; step(); #1;
        n_checks++; if (insvc32 !== 32'h4000_0000) begin n_err++; $display("FAIL wide_eret1: got %h want 40000000", insvc32); end
        step(); eret32 = 1'b0; #1;
        n_checks++; if (insvc32 !== 32'h0 || wait32 !== 32'h0) begin n_err++; $display("FAIL wide_eret2: got insvc=%h wait=%h want 0/0", insvc32, wait32); end
    endtask

    task automatic test_random();
        clr = 1'b1; step(); clr = 1'b0;
        for (int c = 0; c < 400; c++) begin
            sig4  = 4'($urandom_range(0, 15));
            mask4 = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
            en    = ($urandom_range(0, 9) != 0);
            ack   = 1'($urandom_range(0, 1));
            eret  = ($urandom_range(0, 3) == 0);
            clr   = ($urandom_range(0, 99) == 0);
            #1;
            n_checks++; if (req4 !== m_req()) begin n_err++; $display("FAIL rnd_req c%0d: got %b want %b", c, req4, m_req()); end
            n_checks++; if (num4 !== m_num()) begin n_err++; $display("FAIL rnd_num c%0d: got %0d want %0d", c, num4, m_num()); end
            n_checks++; if (wait4 !== (m_pend | m_insvc())) begin n_err++; $display("FAIL rnd_wait c%0d: got %b want %b", c, wait4, m_pend | m_insvc()); end
            n_checks++; if (insvc4 !== m_insvc()) begin n_err++; $display("FAIL rnd_insvc c%0d: got %b want %b", c, insvc4, m_insvc()); end
            n_checks++; if (ovr4 !== m_ovr) begin n_err++; $display("FAIL rnd_ovr c%0d: got %b want %b", c, ovr4, m_ovr); end
            step();
        end
        {clr, ack, eret, mask4} = '0;
        en = 1'b1;
    endtask

    initial begin
        n_err = 0; n_checks = 0;
        clr = 1'b0; en = 1'b1; ack = 1'b0; eret = 1'b0; sig4 = '0; mask4 = '0;
        clr32 = 1'b0; en32 = 1'b1; ack32 = 1'b0; eret32 = 1'b0; sig32 = '0; mask32 = '0;
        m_pend = '0; m_ovr = '0; m_sigq = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_nesting();
        test_no_preempt();
        test_mask_enable();
        test_overrun();
        test_reset_mid();
        test_wide();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
